// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the backing-memory port arbiter: FSM states, grant
// encoding and the beat-index width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2
    } arb_state_t;

    // Side that owned the most recently completed transfer.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Width of a beat index within a line of line_words words.
    function automatic int unsigned beat_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of I-side, D-side and memory-side signals around the arbiter.
// master = arbiter view, slave = requesters + memory view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BEAT_W = 2
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic [BEAT_W-1:0] i_beat;
    logic              i_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic [BEAT_W-1:0] d_beat;
    logic              d_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  i_req, i_addr,
        output i_rvalid, i_rdata, i_beat, i_done,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rvalid, d_rdata, d_beat, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output i_req, i_addr,
        input  i_rvalid, i_rdata, i_beat, i_done,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rvalid, d_rdata, d_beat, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_beat_counter.sv
// Beat index within the current transfer: advances on each memory ack,
// returns to zero when the transfer completes or on reset.
module mem_beat_counter #(
    parameter int unsigned BEAT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [BEAT_W-1:0] beat,
    output logic              last
);

    // Beat register: clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            beat <= '0;
        end else if (inc) begin
            beat <= beat + BEAT_W'(1);
        end
    end

    // Line length is a power of two, so the final beat is all ones.
    assign last = &beat;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between I-side line refills and D-side
// line refills / single-word writes, alternating on conflict.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.master bus
);

    localparam int unsigned BEAT_W = beat_w(LINE_WORDS);

    arb_state_t        state, state_nx;
    grant_t            last_grant;
    logic [ADDR_W-3:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BEAT_W-1:0] beat;
    logic              beat_last;
    logic              i_own, d_own, busy, xfer_done;
    logic              grant_i, grant_d;
    logic [ADDR_W-1:0] read_addr, write_addr;
    logic              unused_addr_bits;

    assign i_own     = (state == I_XFER);
    assign d_own     = (state == D_XFER);
    assign busy      = i_own | d_own;
    assign xfer_done = busy & bus.mem_ack & (we_q | beat_last);

    // Byte-offset bits of the request addresses never reach the memory.
    assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

    // Grant selection in IDLE and return to IDLE on the final ack.
    always_comb begin
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.d_req && (!bus.i_req || last_grant == GRANT_I)) begin
                    grant_d  = 1'b1;
                    state_nx = D_XFER;
                end else if (bus.i_req) begin
                    grant_i  = 1'b1;
                    state_nx = I_XFER;
                end
            end
            I_XFER, D_XFER: begin
                if (xfer_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and record of which side was served last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state <= state_nx;
            if (xfer_done) begin
                last_grant <= d_own ? GRANT_D : GRANT_I;
            end
        end
    end

    // Capture the granted request so later requester changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (grant_d) begin
            addr_q  <= bus.d_addr[ADDR_W-1:2];
            we_q    <= bus.d_we;
            wdata_q <= bus.d_wdata;
        end else if (grant_i) begin
            addr_q  <= bus.i_addr[ADDR_W-1:2];
            we_q    <= 1'b0;
            wdata_q <= '0;
        end
    end

    mem_beat_counter #(
        .BEAT_W (BEAT_W)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (busy & bus.mem_ack),
        .clr  (xfer_done),
        .beat (beat),
        .last (beat_last)
    );

    assign read_addr  = {addr_q[ADDR_W-3:BEAT_W], beat, 2'b00};
    assign write_addr = {addr_q, 2'b00};

    assign bus.mem_req   = busy;
    assign bus.mem_we    = d_own & we_q;
    assign bus.mem_addr  = busy ? (we_q ? write_addr : read_addr) : '0;
    assign bus.mem_wdata = (d_own & we_q) ? wdata_q : '0;

    // Read data is passed straight through to whichever side owns the port.
    assign bus.i_rvalid = i_own & bus.mem_ack;
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.i_beat   = i_own ? beat : '0;
    assign bus.i_done   = i_own & xfer_done;

    assign bus.d_rvalid = d_own & ~we_q & bus.mem_ack;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
    assign bus.d_beat   = d_own ? beat : '0;
    assign bus.d_done   = d_own & xfer_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: scripted requesters and a memory
// with wait states, checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned LW     = 4;
    localparam int unsigned BW     = beat_w(LW);
    localparam int          SIDE_I = 1;
    localparam int          SIDE_D = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .BEAT_W(BW)) bus ();

    mem_port_arbiter #(
        .LINE_WORDS (LW),
        .ADDR_W     (32),
        .DATA_W     (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned gap;
    } txn_t;

    txn_t iq[$];
    txn_t dq[$];
    txn_t i_cur, d_cur;
    bit   i_pend, d_pend;

    // Model: who owns the port this cycle (0 = nobody), beat reached, last served side.
    int          m_owner;
    int unsigned m_beat;
    int          m_last;
    txn_t        m_txn;

    int unsigned ws_min, ws_max, ws_left;
    bit          spurious, drop_mid, rst_on_beat2, rst_req, armed, just_reset;
    int unsigned busy_cycles, i_dones, d_dones, d_rv_seen, i_other, d_other;
    int          glog[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic clear_stats();
        busy_cycles = 0;
        i_dones     = 0;
        d_dones     = 0;
        d_rv_seen   = 0;
        glog.delete();
    endtask

    // One clock cycle: memory response, checks, requester updates, model advance.
    task automatic step();
        logic        ack;
        logic [31:0] rdata, exp_addr;
        bit          own_i, own_d, exp_last, ev_i, ev_d, was_idle;
        txn_t        t;

        @(negedge clk);
        if (bus.mem_req === 1'b1) begin
            ack = (ws_left == 0);
            if (ack) ws_left = $urandom_range(ws_max, ws_min);
            else     ws_left--;
            rdata = mem_fn(bus.mem_addr);
        end else begin
            ws_left = $urandom_range(ws_max, ws_min);
            ack     = spurious && ($urandom_range(3, 0) == 0);
            rdata   = $urandom;
        end
        bus.mem_ack   = ack;
        bus.mem_rdata = rdata;
        #1;

        own_i    = (m_owner == SIDE_I);
        own_d    = (m_owner == SIDE_D);
        exp_last = m_txn.we || (m_beat == LW - 1);
        ev_i     = own_i && ack;
        ev_d     = own_d && ack;
        exp_addr = m_txn.we ? (m_txn.addr & ~32'h3)
                            : ((m_txn.addr & ~(LW * 4 - 1)) + 4 * m_beat);

        if (armed) begin
            check("mem_req", 64'(bus.mem_req), 64'(m_owner != 0));
            if (m_owner != 0) begin
                check("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
                check("mem_we", 64'(bus.mem_we), 64'(m_txn.we));
                check("mem_wdata", 64'(bus.mem_wdata), 64'(m_txn.we ? m_txn.wdata : 32'h0));
            end else begin
                check("idle_bus", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'(0));
            end
            check("i_resp", 64'({bus.i_rvalid, bus.i_done, bus.i_rdata}),
                  64'({ev_i, ev_i && exp_last, ev_i ? rdata : 32'h0}));
            check("d_resp", 64'({bus.d_rvalid, bus.d_done, bus.d_rdata}),
                  64'({ev_d && !m_txn.we, ev_d && exp_last, (ev_d && !m_txn.we) ? rdata : 32'h0}));
            if (ev_i || !own_i) check("i_beat", 64'(bus.i_beat), 64'(own_i ? m_beat : 0));
            if (ev_d || !own_d) check("d_beat", 64'(bus.d_beat), 64'(own_d ? m_beat : 0));
            if (just_reset) begin
                check("rst_abort", 64'(|{bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                         bus.i_rvalid, bus.i_done, bus.i_beat, bus.i_rdata,
                                         bus.d_rvalid, bus.d_done, bus.d_beat, bus.d_rdata}), 64'(0));
                just_reset = 0;
            end
            if (bus.mem_req === 1'b1) busy_cycles++;
            if (bus.d_rvalid === 1'b1) d_rv_seen++;
        end

        // Model: an ack advances the beat; the final ack ends the transfer.
        was_idle = (m_owner == 0);
        if (m_owner != 0 && ack) begin
            if (exp_last) begin
                m_last  = m_owner;
                m_owner = 0;
                m_beat  = 0;
            end else begin
                m_beat++;
            end
        end

        // Requesters react to the done pulses they observe.
        if (bus.d_done === 1'b1 && i_pend) i_other++;
        if (bus.i_done === 1'b1 && d_pend) d_other++;
        if (bus.i_done === 1'b1 && i_pend) begin
            i_pend = 0;
            i_dones++;
            glog.push_back(SIDE_I);
            check("i_fair", 64'(i_other <= 1), 64'(1));
        end
        if (bus.d_done === 1'b1 && d_pend) begin
            d_pend = 0;
            d_dones++;
            glog.push_back(SIDE_D);
            check("d_fair", 64'(d_other <= 1), 64'(1));
        end
        if (drop_mid && i_pend && own_i && m_owner == SIDE_I && $urandom_range(3, 0) == 0) begin
            bus.i_req  = 1'b0;
            bus.i_addr = $urandom;
        end
        if (drop_mid && d_pend && own_d && m_owner == SIDE_D && $urandom_range(3, 0) == 0) begin
            bus.d_req   = 1'b0;
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.d_we    = $urandom_range(1, 0) == 1;
        end
        if (!i_pend) begin
            if (iq.size() > 0 && iq[0].gap == 0) begin
                i_cur      = iq.pop_front();
                i_pend     = 1;
                i_other    = 0;
                bus.i_req  = 1'b1;
                bus.i_addr = i_cur.addr;
            end else begin
                if (iq.size() > 0) begin
                    t = iq[0]; t.gap--; iq[0] = t;
                end
                bus.i_req = 1'b0;
            end
        end
        if (!d_pend) begin
            if (dq.size() > 0 && dq[0].gap == 0) begin
                d_cur       = dq.pop_front();
                d_pend      = 1;
                d_other     = 0;
                bus.d_req   = 1'b1;
                bus.d_we    = d_cur.we;
                bus.d_addr  = d_cur.addr;
                bus.d_wdata = d_cur.wdata;
            end else begin
                if (dq.size() > 0) begin
                    t = dq[0]; t.gap--; dq[0] = t;
                end
                bus.d_req = 1'b0;
            end
        end

        if (rst_req || (rst_on_beat2 && bus.i_rvalid === 1'b1 && bus.i_beat == 2)) begin
            rst          = 1'b1;
            rst_req      = 0;
            rst_on_beat2 = 0;
            iq.delete();
            dq.delete();
            i_pend      = 0;
            d_pend      = 0;
            bus.i_req   = 1'b0;
            bus.d_req   = 1'b0;
            m_owner     = 0;
            m_beat      = 0;
            m_last      = SIDE_I;
            armed       = 1;
            just_reset  = 1;
        end else begin
            rst = 1'b0;
            // A free port is given to the only waiting side, or when both wait,
            // to the side that was not served last.
            if (was_idle) begin
                if (bus.d_req && (!bus.i_req || m_last == SIDE_I)) begin
                    m_owner = SIDE_D;
                    m_txn   = d_cur;
                end else if (bus.i_req) begin
                    m_owner  = SIDE_I;
                    m_txn    = i_cur;
                    m_txn.we = 0;
                end
                m_beat = 0;
            end
        end
    endtask

    task automatic run_idle(input int unsigned bound);
        int unsigned n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || i_pend || d_pend || m_owner != 0) && n < bound) begin
            step();
            n++;
        end
        check("drained", 64'(n < bound), 64'(1));
        step();
    endtask

    int exp_order[6] = '{SIDE_D, SIDE_I, SIDE_D, SIDE_I, SIDE_D, SIDE_I};

    initial begin
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        ws_min = 0; ws_max = 0; ws_left = 0;
        spurious = 0; drop_mid = 0; rst_on_beat2 = 0; armed = 0; just_reset = 0;
        m_owner = 0; m_beat = 0; m_last = SIDE_I;
        m_txn = '{0, 32'h0, 32'h0, 0};
        i_pend = 0; d_pend = 0; i_other = 0; d_other = 0;
        clear_stats();

        // Reset and idle state.
        rst_req = 1; step();
        rst_req = 1; step();
        step();
        step();

        // I-only line read at 0x104, immediate acks.
        clear_stats();
        iq.push_back('{0, 32'h104, 32'h0, 0});
        run_idle(200);
        check("iread_busy", 64'(busy_cycles), 64'(4));
        check("iread_done", 64'(i_dones), 64'(1));

        // D single-word write.
        clear_stats();
        dq.push_back('{1, 32'h2002, 32'hDEAD_BEEF, 0});
        run_idle(200);
        check("dwrite_busy", 64'(busy_cycles), 64'(1));
        check("dwrite_done", 64'(d_dones), 64'(1));
        check("dwrite_rvalid", 64'(d_rv_seen), 64'(0));

        // Simultaneous requests after reset, both sides keeping req high.
        rst_req = 1; step();
        clear_stats();
        for (int k = 0; k < 3; k++) begin
            iq.push_back('{0, 32'h1000 + 32'(k) * 32'h40, 32'h0, 0});
            dq.push_back('{k == 1, 32'h8000 + 32'(k) * 32'h44, $urandom, 0});
        end
        run_idle(500);
        check("order_len", 64'(glog.size()), 64'(6));
        for (int k = 0; k < 6; k++) begin
            check("order", 64'(k < glog.size() ? glog[k] : 0), 64'(exp_order[k]));
        end

        // Three wait states per beat.
        clear_stats();
        ws_min = 3; ws_max = 3;
        iq.push_back('{0, 32'h3008, 32'h0, 0});
        run_idle(500);
        check("ws_busy", 64'(busy_cycles), 64'(16));
        check("ws_done", 64'(i_dones), 64'(1));
        ws_min = 0; ws_max = 0;

        // Reset in the middle of an I read, then a normal D read.
        clear_stats();
        rst_on_beat2 = 1;
        iq.push_back('{0, 32'h4000, 32'h0, 0});
        for (int k = 0; k < 50 && rst_on_beat2; k++) step();
        check("rst_hit", 64'(rst_on_beat2), 64'(0));
        step();
        check("rst_no_done", 64'(i_dones), 64'(0));
        dq.push_back('{0, 32'h5000, 32'h0, 0});
        run_idle(200);
        check("post_rst_done", 64'(d_dones), 64'(1));

        // Random traffic: wait states, spurious idle acks, mid-transfer drops.
        clear_stats();
        ws_min = 0; ws_max = 3; spurious = 1; drop_mid = 1;
        for (int k = 0; k < 150; k++) begin
            iq.push_back('{0, $urandom, 32'h0,
                           ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(4, 0)});
            dq.push_back('{$urandom_range(1, 0) == 1, $urandom, $urandom,
                           ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(4, 0)});
        end
        run_idle(20000);
        check("rand_i_done", 64'(i_dones), 64'(150));
        check("rand_d_done", 64'(d_dones), 64'(150));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
